// File: rtl/guess_checker.sv
// Memory-style guessing game controller: shows an LFSR-derived BCD target, then scores one keypad guess per round.
// Optional build macro PARTIAL_MATCH_EN adds the correct_digits output and per-digit scoring.
module guess_checker #(
  parameter int          SHOW_CYCLES = 100000000,
  parameter int          LIVES       = 3,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] value,
  input  logic        value_ready,
  output logic        kbd_rst,
  output logic [15:0] target,
  output logic        show_target,
  output logic        result_valid,
  output logic        match,
  output logic [7:0]  score,
  output logic [1:0]  lives,
  output logic        game_over
`ifdef PARTIAL_MATCH_EN
  ,
  output logic [2:0]  correct_digits
`endif
);

  localparam int CNT_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SHOW_LOAD = CNT_W'(SHOW_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHOW   = 3'd1,
    ARM    = 3'd2,
    WAIT   = 3'd3,
    EVAL   = 3'd4,
    RESULT = 3'd5,
    OVER   = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [15:0]      target_q, target_d;
  logic [15:0]      guess_q, guess_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;
  logic             match_q, match_d;
  logic             result_valid_q, result_valid_d;
  logic [7:0]       score_q, score_d;
  logic [1:0]       lives_q, lives_d;
  logic             full_hit;
  logic [7:0]       score_inc;
  logic [8:0]       score_sum;
`ifdef PARTIAL_MATCH_EN
  logic [2:0]       hits;
  logic [2:0]       correct_digits_q, correct_digits_d;
`endif

  function automatic logic [3:0] to_digit(input logic [3:0] n);
    return (n > 4'd9) ? (n - 4'd10) : n;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      lfsr_q           <= LFSR_SEED;
      target_q         <= '0;
      guess_q          <= '0;
      cnt_q            <= '0;
      first_q          <= 1'b1;
      match_q          <= 1'b0;
      result_valid_q   <= 1'b0;
      score_q          <= '0;
      lives_q          <= 2'(LIVES);
`ifdef PARTIAL_MATCH_EN
      correct_digits_q <= '0;
`endif
    end else begin
      state_q          <= state_d;
      lfsr_q           <= lfsr_d;
      target_q         <= target_d;
      guess_q          <= guess_d;
      cnt_q            <= cnt_d;
      first_q          <= first_d;
      match_q          <= match_d;
      result_valid_q   <= result_valid_d;
      score_q          <= score_d;
      lives_q          <= lives_d;
`ifdef PARTIAL_MATCH_EN
      correct_digits_q <= correct_digits_d;
`endif
    end
  end

  // Guess scoring: full match always counts one point unless per-digit scoring is built in
  always_comb begin
`ifdef PARTIAL_MATCH_EN
    hits = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (guess_q[4*i +: 4] == target_q[4*i +: 4]) hits = hits + 3'd1;
    end
    full_hit  = (hits == 3'd4);
    score_inc = {5'd0, hits};
`else
    full_hit  = (guess_q == target_q);
    score_inc = full_hit ? 8'd1 : 8'd0;
`endif
    score_sum = {1'b0, score_q} + {1'b0, score_inc};
  end

  always_comb begin
    state_d        = state_q;
    lfsr_d         = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    target_d       = target_q;
    guess_d        = guess_q;
    cnt_d          = cnt_q;
    first_d        = first_q;
    match_d        = match_q;
    result_valid_d = 1'b0;
    score_d        = score_q;
    lives_d        = lives_q;
`ifdef PARTIAL_MATCH_EN
    correct_digits_d = correct_digits_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          // A missed target is replayed until the player gets it right
          if (first_q || match_q) begin
            target_d = {to_digit(lfsr_q[15:12]), to_digit(lfsr_q[11:8]),
                        to_digit(lfsr_q[7:4]), to_digit(lfsr_q[3:0])};
          end
          first_d = 1'b0;
          cnt_d   = SHOW_LOAD;
          state_d = SHOW;
        end
      end
      SHOW: begin
        if (cnt_q == '0) state_d = ARM;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ARM: state_d = WAIT;
      WAIT: begin
        if (value_ready) begin
          guess_d = value;
          state_d = EVAL;
        end
      end
      EVAL: begin
        result_valid_d = 1'b1;
        match_d        = full_hit;
        score_d        = score_sum[8] ? 8'hFF : score_sum[7:0];
        if (!full_hit && lives_q != 2'd0) lives_d = lives_q - 2'd1;
`ifdef PARTIAL_MATCH_EN
        correct_digits_d = hits;
`endif
        state_d = RESULT;
      end
      RESULT: state_d = (lives_q == 2'd0) ? OVER : IDLE;
      OVER:   state_d = OVER;
      default: state_d = IDLE;
    endcase
  end

  assign kbd_rst      = rst || (state_q == ARM) || ((state_q == RESULT) && (lives_q != 2'd0));
  assign show_target  = (state_q == SHOW);
  assign game_over    = (state_q == OVER);
  assign target       = target_q;
  assign result_valid = result_valid_q;
  assign match        = match_q;
  assign score        = score_q;
  assign lives        = lives_q;
`ifdef PARTIAL_MATCH_EN
  assign correct_digits = correct_digits_q;
`endif

endmodule

// File: tb/tb_guess_checker.sv
// Directed bench for guess_checker with an expected-result scoreboard; SHOW_CYCLES=4, LIVES=3.
module tb_guess_checker;

  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk, rst, start, value_ready;
  logic [15:0] value;
  logic        kbd_rst, show_target, result_valid, match, game_over;
  logic [15:0] target;
  logic [7:0]  score;
  logic [1:0]  lives;
`ifdef PARTIAL_MATCH_EN
  logic [2:0]  correct_digits;
`endif

  guess_checker #(.SHOW_CYCLES(4), .LIVES(3), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .start(start), .value(value), .value_ready(value_ready),
    .kbd_rst(kbd_rst), .target(target), .show_target(show_target),
    .result_valid(result_valid), .match(match), .score(score), .lives(lives),
    .game_over(game_over)
`ifdef PARTIAL_MATCH_EN
    , .correct_digits(correct_digits)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       m;
    logic [7:0] s;
    logic [1:0] l;
    logic [2:0] cd;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] lfsr_m;
  logic [15:0] exp_tgt;
  logic [7:0]  m_score;
  logic [1:0]  m_lives;
  logic        m_first, m_match, m_over;

  always @(posedge clk) begin
    if (rst) lfsr_m <= SEED;
    else     lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end

  function automatic logic [15:0] map_target(input logic [15:0] r);
    logic [15:0] t;
    for (int i = 0; i < 4; i++) begin
      t[4*i +: 4] = (r[4*i +: 4] > 4'd9) ? r[4*i +: 4] - 4'd10 : r[4*i +: 4];
    end
    return t;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] ex);
    n_vec++;
    assert (obs === ex) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, ex);
    end
  endtask

  task automatic model_reset();
    m_score = 8'd0; m_lives = 2'd3; m_first = 1'b1; m_match = 1'b0; m_over = 1'b0;
    exp_tgt = 16'h0000;
    sb.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_kbd_rst"}, {31'd0, kbd_rst}, 32'd1);
    check({tag, "_target"}, {16'd0, target}, 32'd0);
    check({tag, "_show"}, {31'd0, show_target}, 32'd0);
    check({tag, "_rv"}, {31'd0, result_valid}, 32'd0);
    check({tag, "_match"}, {31'd0, match}, 32'd0);
    check({tag, "_score"}, {24'd0, score}, 32'd0);
    check({tag, "_lives"}, {30'd0, lives}, 32'd3);
    check({tag, "_game_over"}, {31'd0, game_over}, 32'd0);
  endtask

  // start pulse, then watch an 8-cycle window covering SHOW and ARM
  task automatic start_round(input string tag);
    int n_show, n_kbd;
    logic ok;
    n_show = 0; n_kbd = 0;
    @(negedge clk);
    start = 1'b1;
    if (!m_over && (m_first || m_match)) exp_tgt = map_target(lfsr_m);
    if (!m_over) m_first = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (show_target) n_show++;
      if (kbd_rst) n_kbd++;
    end
    check({tag, "_show_cycles"}, n_show, m_over ? 0 : 4);
    check({tag, "_kbd_pulses"}, n_kbd, m_over ? 0 : 1);
    check({tag, "_target"}, {16'd0, target}, {16'd0, exp_tgt});
    ok = 1'b1;
    for (int i = 0; i < 4; i++) if (target[4*i +: 4] > 4'd9) ok = 1'b0;
    check({tag, "_bcd"}, {31'd0, ok}, 32'd1);
  endtask

  task automatic guess(input string tag, input logic [15:0] val);
    exp_t ex, got;
    int   h, lat;
    logic seen;
    h = 0;
    for (int i = 0; i < 4; i++) if (val[4*i +: 4] == exp_tgt[4*i +: 4]) h++;
`ifdef PARTIAL_MATCH_EN
    m_score = (int'(m_score) + h > 255) ? 8'hFF : m_score + 8'(h);
`else
    if (h == 4) m_score = (m_score == 8'hFF) ? 8'hFF : m_score + 8'd1;
`endif
    if (h != 4) m_lives = m_lives - 2'd1;
    m_match = (h == 4);
    ex.m = m_match; ex.s = m_score; ex.l = m_lives; ex.cd = 3'(h);
    @(negedge clk);
    value = val; value_ready = 1'b1;
    sb.push_back(ex);
    seen = 1'b0; lat = 0;
    for (int i = 1; i <= 10 && !seen; i++) begin
      @(negedge clk);
      value_ready = 1'b0;
      if (result_valid) begin
        seen = 1'b1; lat = i;
        if (sb.size() == 0) check({tag, "_sb_underflow"}, 32'd1, 32'd0);
        else begin
          got = sb.pop_front();
          check({tag, "_match"}, {31'd0, match}, {31'd0, got.m});
          check({tag, "_score"}, {24'd0, score}, {24'd0, got.s});
          check({tag, "_lives"}, {30'd0, lives}, {30'd0, got.l});
`ifdef PARTIAL_MATCH_EN
          check({tag, "_correct_digits"}, {29'd0, correct_digits}, {29'd0, got.cd});
`endif
          check({tag, "_kbd_rst"}, {31'd0, kbd_rst}, {31'd0, got.l != 2'd0});
        end
      end
    end
    check({tag, "_latency"}, lat, 2);
    @(negedge clk);
    check({tag, "_rv_pulse"}, {31'd0, result_valid}, 32'd0);
    m_over = (m_lives == 2'd0);
    check({tag, "_game_over"}, {31'd0, game_over}, {31'd0, m_over});
  endtask

  function automatic logic [15:0] wrong_value();
    return (exp_tgt == 16'h1234) ? 16'h1235 : 16'h1234;
  endfunction

  initial begin
    int n_rv, n_show;
    logic [15:0] prev_tgt;
    rst = 1'b1; start = 1'b0; value = 16'h0; value_ready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    start_round("r1");
    guess("r1_hit", exp_tgt);

    start_round("r2");
    guess("r2_miss", wrong_value());

    prev_tgt = exp_tgt;
    start_round("r3");
    check("r3_target_kept", {16'd0, target}, {16'd0, prev_tgt});
    guess("r3_miss", wrong_value());

    start_round("r4");
    guess("r4_miss", wrong_value());

    start_round("over_start");
    check("over_latched", {31'd0, game_over}, 32'd1);
    check("over_lives", {30'd0, lives}, 32'd0);

    // abort mid-SHOW
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_reset();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1;
    check("mid_show_active", {31'd0, show_target}, 32'd1);
    @(negedge clk);
    check_reset_outputs("mid_show");
    rst = 1'b0;
    model_reset();
    n_rv = 0; n_show = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (result_valid) n_rv++;
      if (show_target) n_show++;
    end
    check("abort_no_rv", n_rv, 0);
    check("abort_no_show", n_show, 0);

    start_round("r5");
    guess("r5_hit", exp_tgt);
    start_round("r6");
    guess("r6_hit", exp_tgt);

    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
